// File: rtl/parking_occupancy.sv
// Parking lot occupancy tracker: counts inc/dec events, keeps sticky error and abort
// statistics, and converts the count to three BCD digits with a serial double-dabble.
module parking_occupancy #(
  parameter int CAPACITY = 200,
  parameter int ABORT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  input  logic               abort,
  input  logic               clr_err,
  output logic [7:0]         count,
  output logic               full,
  output logic               empty,
  output logic               err_over,
  output logic               err_under,
  output logic [ABORT_W-1:0] abort_cnt,
  output logic [3:0]         bcd_hund,
  output logic [3:0]         bcd_tens,
  output logic [3:0]         bcd_ones,
  output logic               bcd_valid,
  output logic               bcd_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [7:0]         CAP_C     = 8'(CAPACITY);
  localparam logic [ABORT_W-1:0] ABORT_MAX = {ABORT_W{1'b1}};
  localparam logic [ABORT_W-1:0] ABORT_ONE = {{(ABORT_W-1){1'b0}}, 1'b1};

  if (CAPACITY < 1 || CAPACITY > 255) begin : g_cap_check
    $error("parking_occupancy: CAPACITY must be in 1..255");
  end

  logic [7:0]         count_r;
  logic [7:0]         count_nxt_s;
  logic               set_over_s;
  logic               set_under_s;
  logic               err_over_r;
  logic               err_under_r;
  logic [ABORT_W-1:0] abort_cnt_r;
  logic               pending_r;
  logic [1:0]         state_r;
  logic [7:0]         shadow_r;
  logic [11:0]        scratch_r;
  logic [2:0]         iter_r;
  logic [11:0]        digits_r;
  logic               bcd_valid_r;
  logic [19:0]        step_s;

  // One double-dabble iteration: add 3 to any digit >= 5, then shift {bcd, bin} left.
  function automatic logic [19:0] dabble_step(input logic [11:0] bcd, input logic [7:0] bin);
    logic [11:0] adj;
    for (int d = 0; d < 3; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5) begin
        adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end else begin
        adj[d*4 +: 4] = bcd[d*4 +: 4];
      end
    end
    return {adj[10:0], bin, 1'b0};
  endfunction

  // Next count and error events; simultaneous inc and dec cancel out.
  always_comb begin
    count_nxt_s = count_r;
    set_over_s  = 1'b0;
    set_under_s = 1'b0;
    if (inc && !dec) begin
      if (count_r == CAP_C) begin
        set_over_s = 1'b1;
      end else begin
        count_nxt_s = count_r + 8'd1;
      end
    end else if (dec && !inc) begin
      if (count_r == 8'd0) begin
        set_under_s = 1'b1;
      end else begin
        count_nxt_s = count_r - 8'd1;
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  assign step_s = dabble_step(scratch_r, shadow_r);

  // Occupancy, sticky errors, abort statistics and change-pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r     <= 8'd0;
      err_over_r  <= 1'b0;
      err_under_r <= 1'b0;
      abort_cnt_r <= {ABORT_W{1'b0}};
      pending_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      if (set_over_s) begin
        err_over_r <= 1'b1;
      end else if (clr_err) begin
        err_over_r <= 1'b0;
      end
      if (set_under_s) begin
        err_under_r <= 1'b1;
      end else if (clr_err) begin
        err_under_r <= 1'b0;
      end
      // A fresh abort arriving with clr_err restarts the count at one.
      if (clr_err) begin
        abort_cnt_r <= abort ? ABORT_ONE : {ABORT_W{1'b0}};
      end else if (abort && abort_cnt_r != ABORT_MAX) begin
        abort_cnt_r <= abort_cnt_r + ABORT_ONE;
      end
      if (count_nxt_s != count_r) begin
        pending_r <= 1'b1;
      end else if (state_r == ST_LOAD) begin
        pending_r <= 1'b0;
      end
    end
  end

  // Serial BCD converter working on a shadow copy of the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      shadow_r    <= 8'd0;
      scratch_r   <= 12'd0;
      iter_r      <= 3'd0;
      digits_r    <= 12'd0;
      bcd_valid_r <= 1'b0;
    end else begin
      bcd_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pending_r) begin
            state_r <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          shadow_r  <= count_r;
          scratch_r <= 12'd0;
          iter_r    <= 3'd0;
          state_r   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          {scratch_r, shadow_r} <= step_s;
          iter_r <= iter_r + 3'd1;
          if (iter_r == 3'd7) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          digits_r    <= scratch_r;
          bcd_valid_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign count     = count_r;
  assign full      = (count_r == CAP_C);
  assign empty     = (count_r == 8'd0);
  assign err_over  = err_over_r;
  assign err_under = err_under_r;
  assign abort_cnt = abort_cnt_r;
  assign bcd_hund  = digits_r[11:8];
  assign bcd_tens  = digits_r[7:4];
  assign bcd_ones  = digits_r[3:0];
  assign bcd_valid = bcd_valid_r;
  assign bcd_busy  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_parking_occupancy.sv
// Directed bench for parking_occupancy: a vector table for single-cycle counter
// behaviour plus hand-written sequences for conversion latency, overlap and reset.
module tb_parking_occupancy;

  logic       clk = 1'b0;
  logic       rst, inc, dec, abort, clr_err;
  logic [7:0] count, abort_cnt;
  logic       full, empty, err_over, err_under;
  logic [3:0] bcd_hund, bcd_tens, bcd_ones;
  logic       bcd_valid, bcd_busy;

  int checks   = 0;
  int failures = 0;
  int vcnt     = 0;
  int last_h, last_t, last_o;
  int lat, v0;

  typedef struct {
    logic       inc, dec, abort, clr;
    logic [7:0] cnt;
    logic       full, empty, eo, eu;
    logic [7:0] ab;
  } vec_t;
  vec_t vecs[16];

  parking_occupancy #(.CAPACITY(200), .ABORT_W(8)) dut (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .abort(abort), .clr_err(clr_err),
    .count(count), .full(full), .empty(empty), .err_over(err_over), .err_under(err_under),
    .abort_cnt(abort_cnt), .bcd_hund(bcd_hund), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .bcd_valid(bcd_valid), .bcd_busy(bcd_busy)
  );

  always #5 clk = ~clk;

  // Count every bcd_valid pulse and remember the digits it carried.
  always @(negedge clk) begin
    if (bcd_valid) begin
      vcnt++;
      last_h = bcd_hund;
      last_t = bcd_tens;
      last_o = bcd_ones;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic i, input logic d, input logic a, input logic c);
    inc = i; dec = d; abort = a; clr_err = c;
    @(posedge clk); #1;
    inc = 1'b0; dec = 1'b0; abort = 1'b0; clr_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output int l);
    l = -1;
    for (int n = 1; n <= maxc && l < 0; n++) begin
      @(posedge clk); #1;
      if (bcd_valid) l = n;
    end
  endtask

  task automatic chk_digits(input string nm, input int h, input int t, input int o);
    chk({nm, ".hund"}, bcd_hund, h);
    chk({nm, ".tens"}, bcd_tens, t);
    chk({nm, ".ones"}, bcd_ones, o);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, ".count"}, count, 0);
    chk({nm, ".full"}, full, 0);
    chk({nm, ".empty"}, empty, 1);
    chk({nm, ".err_over"}, err_over, 0);
    chk({nm, ".err_under"}, err_under, 0);
    chk({nm, ".abort_cnt"}, abort_cnt, 0);
    chk({nm, ".valid"}, bcd_valid, 0);
    chk({nm, ".busy"}, bcd_busy, 0);
    chk_digits(nm, 0, 0, 0);
  endtask

  initial begin
    //               inc   dec   abt   clr   cnt    full  empty eo    eu    abort
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

    rst = 1'b1; inc = 1'b0; dec = 1'b0; abort = 1'b0; clr_err = 1'b0;
    idle(3);
    rst = 1'b0;
    chk_reset_state("reset");

    // Three spaced entries, each converted 11 edges after the count change.
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("t1.count%0d", k), count, k);
      wait_valid(20, lat);
      chk($sformatf("t1.latency%0d", k), lat, 11);
      chk_digits($sformatf("t1.digits%0d", k), 0, 0, k);
      chk($sformatf("t1.full%0d", k), full, 0);
      chk($sformatf("t1.empty%0d", k), empty, 0);
      idle(9);
    end

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].inc, vecs[i].dec, vecs[i].abort, vecs[i].clr);
      chk($sformatf("vec%0d.count", i), count, vecs[i].cnt);
      chk($sformatf("vec%0d.full", i), full, vecs[i].full);
      chk($sformatf("vec%0d.empty", i), empty, vecs[i].empty);
      chk($sformatf("vec%0d.err_over", i), err_over, vecs[i].eo);
      chk($sformatf("vec%0d.err_under", i), err_under, vecs[i].eu);
      chk($sformatf("vec%0d.abort_cnt", i), abort_cnt, vecs[i].ab);
    end
    idle(40);
    chk_digits("vec.final", 0, 0, 1);

    // Underflow from reset, then a new entry together with clr_err.
    do_reset();
    v0 = vcnt;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3.count", count, 0);
    chk("t3.err_under", err_under, 1);
    chk("t3.empty", empty, 1);
    idle(20);
    chk("t3.no_valid", vcnt - v0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t3.count_after", count, 1);
    chk("t3.err_under_clr", err_under, 0);

    // Simultaneous inc and dec at 5 and at 0.
    repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(30);
    chk_digits("t4.five", 0, 0, 5);
    v0 = vcnt;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(20);
    chk("t4.count5", count, 5);
    chk("t4.eo5", err_over, 0);
    chk("t4.eu5", err_under, 0);
    chk("t4.no_valid5", vcnt - v0, 0);
    do_reset();
    v0 = vcnt;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(20);
    chk("t4.count0", count, 0);
    chk("t4.eu0", err_under, 0);
    chk("t4.eo0", err_over, 0);
    chk("t4.no_valid0", vcnt - v0, 0);

    // Fill to capacity, then overflow and boundary behaviour at 200.
    do_reset();
    repeat (200) drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2.count", count, 200);
    chk("t2.full", full, 1);
    chk("t2.empty", empty, 0);
    idle(40);
    chk_digits("t2.digits", 2, 0, 0);
    v0 = vcnt;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(20);
    chk("t4.count200", count, 200);
    chk("t4.eo200", err_over, 0);
    chk("t4.no_valid200", vcnt - v0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2.count_over", count, 200);
    chk("t2.err_over", err_over, 1);
    idle(20);
    chk("t2.no_valid_over", vcnt - v0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2.err_over_clr", err_over, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2.count199", count, 199);
    chk("t2.full199", full, 0);

    // Back-to-back entries overlapping a conversion.
    do_reset();
    v0 = vcnt;
    repeat (12) drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5.count", count, 12);
    idle(40);
    chk("t5.pulses", vcnt - v0, 2);
    chk("t5.last_hund", last_h, 0);
    chk("t5.last_tens", last_t, 1);
    chk("t5.last_ones", last_o, 2);
    chk("t5.busy", bcd_busy, 0);

    // Abort saturation, then reset in the middle of a conversion.
    repeat (300) drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6.abort_sat", abort_cnt, 255);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("t6.busy_mid", bcd_busy, 1);
    do_reset();
    chk_reset_state("t6.reset");
    v0 = vcnt;
    idle(30);
    chk("t6.no_valid", vcnt - v0, 0);
    chk_digits("t6.hold", 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
